// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with explicit-select or round-robin
// arbitration; one output register stage, full throughput under out_ready=1.

module stream_mux_rr_lane #(
  parameter int WIDTH = 32
) (
  input  logic             load_en,
  input  logic             mode,
  input  logic             is_sel,
  input  logic             is_gnt,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             xfer,
  output logic [WIDTH-1:0] data_m
);
  // In select mode ready ignores valid; in round-robin mode the grant already implies it.
  assign ready  = load_en && rst_n && (mode ? is_gnt : is_sel);
  assign xfer   = valid && ready;
  assign data_m = xfer ? data : '0;
endmodule

module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch
);
  logic                       load_en;
  logic [SEL_W-1:0]           rr_ptr;
  logic [SEL_W-1:0]           rr_gnt;
  logic                       rr_hit;
  logic [2*N_CH-1:0]          rot;
  logic [N_CH-1:0]            xfer;
  logic [N_CH-1:0][WIDTH-1:0] lane_data;
  logic [WIDTH-1:0]           mux_data;
  logic                       xfer_any;
  logic [SEL_W-1:0]           xfer_ch;

  assign load_en = !out_valid || out_ready;

  // Rotate valids so bit 0 is rr_ptr; the first set bit is the offset of the winner.
  always_comb begin
    int tmp;
    rr_hit = 1'b0;
    rr_gnt = '0;
    tmp    = 0;
    rot    = {in_valid, in_valid} >> rr_ptr;
    for (int k = 0; k < N_CH; k++) begin
      if (!rr_hit && rot[k]) begin
        rr_hit = 1'b1;
        tmp    = int'(rr_ptr) + k;
        if (tmp >= N_CH) tmp = tmp - N_CH;
        rr_gnt = SEL_W'(tmp);
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    stream_mux_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .load_en (load_en),
      .mode    (mode),
      .is_sel  (sel == SEL_W'(g)),
      .is_gnt  (rr_hit && (rr_gnt == SEL_W'(g))),
      .rst_n   (rst_n),
      .valid   (in_valid[g]),
      .data    (in_data[g*WIDTH +: WIDTH]),
      .ready   (in_ready[g]),
      .xfer    (xfer[g]),
      .data_m  (lane_data[g])
    );
  end

  // At most one lane transfers, so an OR of the masked lanes is the mux.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_CH; i++) mux_data = mux_data | lane_data[i];
  end

  assign xfer_any = |xfer;
  assign xfer_ch  = mode ? rr_gnt : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (xfer_any) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_ch    <= xfer_ch;
        if (mode)
          rr_ptr <= (xfer_ch == SEL_W'(N_CH-1)) ? '0 : xfer_ch + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
